// File: rtl/msg_tx_if.sv
// -----------------------------------------------------------------------------
// msg_tx_if
// Byte handshake between the message sequencer and the UART transmitter.
//   tx_valid  master -> slave  tx_data holds a byte offered for transmission
//   tx_data   master -> slave  8-bit byte, stable while tx_valid is high
//   tx_ready  slave  -> master transmitter accepts the byte this cycle
// A byte is transferred on the rising clock edge where tx_valid & tx_ready.
// -----------------------------------------------------------------------------
interface msg_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/msg_tx_sequencer.sv
// -----------------------------------------------------------------------------
// msg_tx_sequencer
// Sends a fixed ASCII message, first character first, into a UART transmitter
// over a valid/ready handshake. One trigger pulse sends one whole message; the
// pause input stops new bytes at byte boundaries but never withdraws a byte
// that is already being offered.
//
// Parameters
//   MSG_LEN   number of bytes in MSG (>= 1)
//   MSG       message string, leftmost character transmitted first
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active high
//   trigger_i  in   1-cycle start pulse
//   pause_i    in   1 = do not issue further bytes
//   active_o   out  a message is in progress
//   done_o     out  1-cycle pulse after the last byte has been accepted
//   tx         msg_tx_if.master  valid/ready byte stream to the UART
//
// Build option
//   MSG_SEQ_TRIG_LATCH_EN  when defined, a trigger arriving during a message
//   is remembered in a one-deep pending flag and starts the next message
//   straight after the current one (no idle cycle in between unless paused).
// -----------------------------------------------------------------------------
module msg_tx_sequencer #(
    parameter int                   MSG_LEN = 13,
    parameter logic [8*MSG_LEN-1:0] MSG     = "Hello World\r\n"
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     trigger_i,
    input  logic     pause_i,
    output logic     active_o,
    output logic     done_o,
    msg_tx_if.master tx
);

    localparam int            IW       = $clog2(MSG_LEN + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_ADV  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [7:0]    data_q,  data_d;
    logic          done_q,  done_d;
    logic          start_req;

    // Message unpacked into a byte table; entry 0 is the leftmost character.
    logic [7:0] msg_rom [MSG_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < MSG_LEN; gi++) begin : g_rom
            assign msg_rom[gi] = MSG[8*(MSG_LEN-1-gi) +: 8];
        end
    endgenerate

`ifdef MSG_SEQ_TRIG_LATCH_EN
    logic pending_q, pending_d;
    assign start_req = trigger_i | pending_q;
`else
    assign start_req = trigger_i;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef MSG_SEQ_TRIG_LATCH_EN
        // Any trigger seen while busy (including the final ADV cycle) is kept.
        pending_d = pending_q | (trigger_i & (state_q != ST_IDLE));
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_req && !pause_i) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
`ifdef MSG_SEQ_TRIG_LATCH_EN
                    pending_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (!pause_i) begin
                    data_d  = msg_rom[idx_q];
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Pause is ignored here: an offered byte stays offered.
                if (tx.tx_ready) begin
                    state_d = ST_ADV;
                end
            end
            default: begin // ST_ADV
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    idx_d   = '0;
`ifdef MSG_SEQ_TRIG_LATCH_EN
                    // Chain straight into the next message; a trigger in this
                    // very cycle re-arms the flag for the one after.
                    if (pending_q && !pause_i) begin
                        state_d   = ST_LOAD;
                        pending_d = trigger_i;
                    end
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

`ifdef MSG_SEQ_TRIG_LATCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`endif

    // All outputs come straight from registers, so reset clears them at once.
    assign tx.tx_valid = (state_q == ST_REQ);
    assign tx.tx_data  = data_q;
    assign active_o    = (state_q != ST_IDLE);
    assign done_o      = done_q;

endmodule
